// File: rtl/lockout_guard_pkg.sv
// Shared answer codes and guard state encoding, imported by the checker,
// servo driver, digit decoder and the lockout guard itself.
package lock_pkg;

    localparam logic [2:0] ANS_IDLE   = 3'd0;
    localparam logic [2:0] ANS_OPEN   = 3'd1;
    localparam logic [2:0] ANS_WRONG  = 3'd2;
    localparam logic [2:0] ANS_LOCKED = 3'd3;

    typedef enum logic [1:0] {
        S_ARMED     = 2'd0,
        S_LOCKOUT   = 2'd1,
        S_WAIT_IDLE = 2'd2
    } lock_state_t;

    // True on the first cycle that the answer shows the given code.
    // Reserved codes 4..7 never match OPEN or WRONG, so they behave as IDLE.
    function automatic logic code_rise(input logic [2:0] cur,
                                       input logic [2:0] prev,
                                       input logic [2:0] code);
        return (cur == code) && (prev != code);
    endfunction

endpackage

// File: rtl/lockout_guard_if.sv
// Result-code path between the passcode checker (master) and the lockout
// guard (slave), plus the guard's status outputs.
interface lockout_guard_if;
    logic [2:0] i_Answer;
    logic [2:0] o_Answer;
    logic       o_Lockout;
    logic [3:0] o_Seconds_Left;
    logic [2:0] o_Fail_Count;
    logic       o_Entry_Clear;

    modport master (
        output i_Answer,
        input  o_Answer, o_Lockout, o_Seconds_Left, o_Fail_Count, o_Entry_Clear
    );

    modport slave (
        input  i_Answer,
        output o_Answer, o_Lockout, o_Seconds_Left, o_Fail_Count, o_Entry_Clear
    );
endinterface

// File: rtl/lockout_guard_sec_tick_gen.sv
// One-second tick generator: counts 0..CLKS_PER_SEC-1 and pulses o_Tick on
// the wrap cycle. i_Clr holds the count at zero so the first tick after
// release lands exactly CLKS_PER_SEC cycles later.
module sec_tick_gen #(
    parameter int CLKS_PER_SEC = 25000000
) (
    input  logic i_Clk,
    input  logic i_Rst_L,
    input  logic i_Clr,
    output logic o_Tick
);
    localparam int CW = (CLKS_PER_SEC > 1) ? $clog2(CLKS_PER_SEC) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_SEC - 1);

    logic [CW-1:0] cnt_r;

    // Free-running second counter, held at zero while cleared.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            cnt_r <= {CW{1'b0}};
        end else if (i_Clr || (cnt_r == LAST)) begin
            cnt_r <= {CW{1'b0}};
        end else begin
            cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
        end
    end

    assign o_Tick = !i_Clr && (cnt_r == LAST);
endmodule

// File: rtl/lockout_guard.sv
// Lockout guard: counts consecutive wrong entries, forces a timed lockout
// that pins the forwarded answer to LOCKED, then waits for the checker to
// go idle before re-arming.
module lockout_guard
    import lock_pkg::*;
#(
    parameter int CLKS_PER_SEC = 25000000,
    parameter int MAX_FAILS    = 3,
    parameter int LOCKOUT_SEC  = 9
) (
    input  logic           i_Clk,
    input  logic           i_Rst_L,
    lockout_guard_if.slave bus
);
    localparam logic [3:0] FAIL_LIMIT = 4'(MAX_FAILS);
    localparam logic [2:0] FAIL_SAT   = 3'(MAX_FAILS);
    localparam logic [3:0] SEC_LOAD   = 4'(LOCKOUT_SEC);

    lock_state_t state_r;
    logic [2:0]  prev_r;
    logic [2:0]  answer_r;
    logic        lockout_r;
    logic [3:0]  seconds_r;
    logic [2:0]  fail_r;
    logic        clear_r;

    logic        tick_s;
    logic        tick_clr_s;
    logic        wrong_evt_s;
    logic        open_evt_s;
    logic [3:0]  fail_next_s;

    assign tick_clr_s  = (state_r != S_LOCKOUT);
    assign wrong_evt_s = code_rise(bus.i_Answer, prev_r, ANS_WRONG);
    assign open_evt_s  = code_rise(bus.i_Answer, prev_r, ANS_OPEN);
    assign fail_next_s = {1'b0, fail_r} + 4'd1;

    sec_tick_gen #(.CLKS_PER_SEC(CLKS_PER_SEC)) u_tick (
        .i_Clk   (i_Clk),
        .i_Rst_L (i_Rst_L),
        .i_Clr   (tick_clr_s),
        .o_Tick  (tick_s)
    );

    // Guard state machine with all outputs registered.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_L) begin
            state_r   <= S_ARMED;
            prev_r    <= ANS_IDLE;
            answer_r  <= ANS_IDLE;
            lockout_r <= 1'b0;
            seconds_r <= 4'd0;
            fail_r    <= 3'd0;
            clear_r   <= 1'b0;
        end else begin
            prev_r  <= bus.i_Answer;
            clear_r <= 1'b0;
            case (state_r)
                S_ARMED: begin
                    answer_r  <= bus.i_Answer;
                    lockout_r <= 1'b0;
                    if (open_evt_s) begin
                        fail_r <= 3'd0;
                    end else if (wrong_evt_s) begin
                        if (fail_next_s >= FAIL_LIMIT) begin
                            state_r   <= S_LOCKOUT;
                            fail_r    <= FAIL_SAT;
                            lockout_r <= 1'b1;
                            seconds_r <= SEC_LOAD;
                            answer_r  <= ANS_LOCKED;
                            clear_r   <= 1'b1;
                        end else begin
                            fail_r <= fail_next_s[2:0];
                        end
                    end else begin
                        fail_r <= fail_r;
                    end
                end
                S_LOCKOUT: begin
                    answer_r  <= ANS_LOCKED;
                    lockout_r <= 1'b1;
                    if (tick_s) begin
                        if (seconds_r <= 4'd1) begin
                            seconds_r <= 4'd0;
                            fail_r    <= 3'd0;
                            clear_r   <= 1'b1;
                            state_r   <= S_WAIT_IDLE;
                        end else begin
                            seconds_r <= seconds_r - 4'd1;
                        end
                    end else begin
                        seconds_r <= seconds_r;
                    end
                end
                S_WAIT_IDLE: begin
                    if (bus.i_Answer == ANS_IDLE) begin
                        state_r   <= S_ARMED;
                        lockout_r <= 1'b0;
                        answer_r  <= ANS_IDLE;
                    end else begin
                        lockout_r <= 1'b1;
                        answer_r  <= ANS_LOCKED;
                    end
                end
                default: begin
                    state_r   <= S_ARMED;
                    answer_r  <= ANS_IDLE;
                    lockout_r <= 1'b0;
                    seconds_r <= 4'd0;
                    fail_r    <= 3'd0;
                end
            endcase
        end
    end

    assign bus.o_Answer       = answer_r;
    assign bus.o_Lockout      = lockout_r;
    assign bus.o_Seconds_Left = seconds_r;
    assign bus.o_Fail_Count   = fail_r;
    assign bus.o_Entry_Clear  = clear_r;
endmodule

// File: tb/tb_lockout_guard.sv
// Self-checking bench for lockout_guard. The reference model tracks the
// lockout as a plain count of remaining cycles and derives the seconds
// display by rounding up.
module tb_lockout_guard;
    localparam int CPS = 10;
    localparam int MF  = 3;
    localparam int LS  = 3;

    logic clk = 1'b0;
    logic rst_l;
    always #5 clk = ~clk;

    lockout_guard_if bus();

    lockout_guard #(.CLKS_PER_SEC(CPS), .MAX_FAILS(MF), .LOCKOUT_SEC(LS)) dut (
        .i_Clk   (clk),
        .i_Rst_L (rst_l),
        .bus     (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: mode 0 armed, 1 locked (timed), 2 waiting for idle.
    int m_mode, m_fail, m_rem, m_out, m_lock, m_clr, m_prev;

    function automatic logic [11:0] model_vec();
        int sec;
        sec = (m_mode == 1) ? (m_rem + CPS - 1) / CPS : 0;
        return {3'(m_out), m_lock[0], 4'(sec), 3'(m_fail), m_clr[0]};
    endfunction

    function automatic logic [11:0] obs_vec();
        return {bus.o_Answer, bus.o_Lockout, bus.o_Seconds_Left, bus.o_Fail_Count, bus.o_Entry_Clear};
    endfunction

    task automatic step(input logic r, input logic [2:0] a);
        rst_l = r;
        bus.i_Answer = a;
        @(posedge clk);
        if (!r) begin
            m_mode = 0; m_fail = 0; m_rem = 0; m_out = 0; m_lock = 0; m_clr = 0; m_prev = 0;
        end else begin
            m_clr = 0;
            if (m_mode == 0) begin
                m_out = a;
                if (a == 3'd1 && m_prev != 1) begin
                    m_fail = 0;
                end else if (a == 3'd2 && m_prev != 2) begin
                    if (m_fail + 1 == MF) begin
                        m_mode = 1; m_fail = MF; m_rem = LS * CPS;
                        m_out = 3; m_lock = 1; m_clr = 1;
                    end else begin
                        m_fail = m_fail + 1;
                    end
                end
            end else if (m_mode == 1) begin
                m_rem = m_rem - 1;
                if (m_rem == 0) begin
                    m_mode = 2; m_fail = 0; m_clr = 1;
                end
            end else begin
                if (a == 3'd0) begin
                    m_mode = 0; m_lock = 0; m_out = 0;
                end
            end
            m_prev = int'(a);
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 3'd2);
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL reset_hold cyc %0d got %h want %h", i, obs_vec(), model_vec());
            end
        end
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 3'd0);
            checks++;
            if (obs_vec() !== 12'h000) begin
                errors++;
                $display("FAIL reset_release cyc %0d got %h want 000", i, obs_vec());
            end
        end
    endtask

    task automatic test_pass_through();
        logic [2:0] seq [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
        for (int i = 0; i < 4; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (obs_vec() !== model_vec() || bus.o_Answer !== seq[i] || bus.o_Fail_Count !== 3'd0) begin
                errors++;
                $display("FAIL pass_through cyc %0d got %h want %h", i, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_two_wrong();
        logic [2:0] seq [9] = '{3'd2, 3'd2, 3'd2, 3'd2, 3'd2, 3'd0, 3'd2, 3'd0, 3'd1};
        logic [2:0] fexp [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd0};
        for (int i = 0; i < 9; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (obs_vec() !== model_vec() || bus.o_Fail_Count !== fexp[i] || bus.o_Lockout !== 1'b0) begin
                errors++;
                $display("FAIL two_wrong cyc %0d got %h want %h fail_want %0d", i, obs_vec(), model_vec(), fexp[i]);
            end
        end
    endtask

    task automatic enter_lockout(input string tag);
        logic [2:0] seq [5] = '{3'd2, 3'd0, 3'd2, 3'd0, 3'd2};
        for (int i = 0; i < 5; i++) begin
            step(1'b1, seq[i]);
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL %s_entry cyc %0d got %h want %h", tag, i, obs_vec(), model_vec());
            end
        end
        checks++;
        if (bus.o_Lockout !== 1'b1 || bus.o_Answer !== 3'd3 || bus.o_Seconds_Left !== 4'd3 || bus.o_Entry_Clear !== 1'b1) begin
            errors++;
            $display("FAIL %s_entry_edge got %h want lockout/3/3/pulse", tag, obs_vec());
        end
    endtask

    task automatic test_lockout();
        int pulses = 0;
        step(1'b1, 3'd0);
        enter_lockout("lockout");
        pulses = 1;
        for (int k = 1; k <= 35; k++) begin
            step(1'b1, 3'd0);
            if (bus.o_Entry_Clear === 1'b1) pulses++;
            checks++;
            if (obs_vec() !== model_vec()) begin
                errors++;
                $display("FAIL lockout cyc %0d got %h want %h", k, obs_vec(), model_vec());
            end
            if (k == 10 || k == 20 || k == 30) begin
                checks++;
                if (bus.o_Seconds_Left !== 4'(LS - k / CPS)) begin
                    errors++;
                    $display("FAIL lockout_seconds at %0d got %0d want %0d", k, bus.o_Seconds_Left, LS - k / CPS);
                end
            end
        end
        checks++;
        if (pulses !== 2) begin
            errors++;
            $display("FAIL lockout_pulses got %0d want 2", pulses);
        end
    endtask

    task automatic test_open_during_lockout();
        enter_lockout("open_lock");
        for (int k = 0; k < 40; k++) begin
            step(1'b1, (k < 3) ? 3'd1 : 3'd2);
            checks++;
            if (obs_vec() !== model_vec() || bus.o_Answer !== 3'd3) begin
                errors++;
                $display("FAIL open_lock cyc %0d got %h want %h", k, obs_vec(), model_vec());
            end
        end
        checks++;
        if (bus.o_Lockout !== 1'b1) begin
            errors++;
            $display("FAIL wait_idle_hold got %b want 1", bus.o_Lockout);
        end
        step(1'b1, 3'd0);
        checks++;
        if (bus.o_Lockout !== 1'b0 || obs_vec() !== model_vec()) begin
            errors++;
            $display("FAIL wait_idle_exit got %h want %h", obs_vec(), model_vec());
        end
        step(1'b1, 3'd2);
        checks++;
        if (bus.o_Fail_Count !== 3'd1 || obs_vec() !== model_vec()) begin
            errors++;
            $display("FAIL post_lock_wrong got %0d want 1", bus.o_Fail_Count);
        end
        step(1'b1, 3'd1);
    endtask

    task automatic test_reset_mid_lockout();
        int budget = 0;
        step(1'b1, 3'd0);
        enter_lockout("mid_rst");
        while (bus.o_Seconds_Left !== 4'd2 && budget < 40) begin
            step(1'b1, 3'd0);
            budget++;
        end
        checks++;
        if (bus.o_Seconds_Left !== 4'd2) begin
            errors++;
            $display("FAIL mid_rst_timeout got %0d want 2", bus.o_Seconds_Left);
        end
        step(1'b0, 3'd0);
        checks++;
        if (obs_vec() !== 12'h000) begin
            errors++;
            $display("FAIL mid_rst_values got %h want 000", obs_vec());
        end
        for (int k = 0; k < 35; k++) begin
            step(1'b1, 3'd0);
            checks++;
            if (obs_vec() !== model_vec() || bus.o_Entry_Clear !== 1'b0) begin
                errors++;
                $display("FAIL mid_rst_after cyc %0d got %h want %h", k, obs_vec(), model_vec());
            end
        end
    endtask

    task automatic test_random();
        logic [2:0] a;
        int v, hold;
        int n = 0;
        while (n < 2000) begin
            v = $urandom_range(0, 9);
            a = (v < 3) ? 3'd0 : (v < 5) ? 3'd1 : (v < 8) ? 3'd2 : (v == 8) ? 3'd3 : 3'($urandom_range(4, 7));
            hold = $urandom_range(1, 4);
            for (int h = 0; h < hold; h++) begin
                step(($urandom_range(0, 299) != 0), a);
                n++;
                checks++;
                if (obs_vec() !== model_vec()) begin
                    errors++;
                    $display("FAIL random cyc %0d got %h want %h", n, obs_vec(), model_vec());
                end
            end
        end
    endtask

    initial begin
        rst_l = 1'b0;
        bus.i_Answer = 3'd0;
        m_mode = 0; m_fail = 0; m_rem = 0; m_out = 0; m_lock = 0; m_clr = 0; m_prev = 0;
        test_reset();
        test_pass_through();
        test_two_wrong();
        test_lockout();
        test_open_during_lockout();
        test_reset_mid_lockout();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
